// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame generator: FSM encoding, default
// line length and the RGB332 -> RGB565 byte expansion used on the pixel bus.
// No ports; imported by cam_sync_gen and cam_frame_gen.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } cam_state_t;

    // Line length at default geometry (2*H_ACT + H_BLANK = 2*160 + 144).
    localparam int L = 2 * 160 + 144;

    function automatic int line_len(input int h_act, input int h_blank);
        return 2 * h_act + h_blank;
    endfunction

    // First byte on the wire: R5 (r replicated) followed by G6[5:3].
    function automatic logic [7:0] rgb332_to_565_hi(input logic [7:0] px);
        return {px[7:5], px[7:6], px[4:2]};
    endfunction

    // Second byte on the wire: G6[2:0] followed by B5 (b replicated).
    function automatic logic [7:0] rgb332_to_565_lo(input logic [7:0] px);
        return {px[4:2], px[1:0], px[1:0], px[1]};
    endfunction

endpackage

// File: rtl/cam_sync_gen.sv
// Frame timing core: horizontal/vertical counters and the IDLE/VSYNC/VBP/ACTIVE/VFP FSM.
// Ports: clk, rst (sync, active-low), en in; vsync (registered), href_early, in_active,
//        frame_start, frame_end, hcnt out. href_early and hcnt lead the output pins by one cycle.
module cam_sync_gen
    import cam_pkg::*;
#(
    parameter int H_ACT       = 160,
    parameter int V_ACT       = 120,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10,
    localparam int LL         = line_len(H_ACT, H_BLANK),
    localparam int HW         = $clog2(LL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          vsync,
    output logic          href_early,
    output logic          in_active,
    output logic          frame_start,
    output logic          frame_end,
    output logic [HW-1:0] hcnt
);

    localparam int VMAX_A = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int VMAX_B = (V_ACT > VFP_LINES) ? V_ACT : VFP_LINES;
    localparam int VMAX   = (VMAX_A > VMAX_B) ? VMAX_A : VMAX_B;
    localparam int VW     = (VMAX > 1) ? $clog2(VMAX) : 1;

    localparam logic [HW-1:0] H_LAST    = HW'(LL - 1);
    localparam logic [HW-1:0] H_ACT_BEG = HW'(H_BLANK);
    localparam logic [VW-1:0] VS_LAST   = VW'(VSYNC_LINES - 1);
    localparam logic [VW-1:0] VBP_LAST  = VW'(VBP_LINES - 1);
    localparam logic [VW-1:0] ACT_LAST  = VW'(V_ACT - 1);
    localparam logic [VW-1:0] VFP_LAST  = VW'(VFP_LINES - 1);

    cam_state_t    state, state_n;
    logic [HW-1:0] hcnt_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic          line_end;
    logic          last_line;

    assign line_end   = (hcnt == H_LAST);
    assign in_active  = (state == ST_ACTIVE);
    assign href_early = in_active && (hcnt >= H_ACT_BEG);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
            vsync <= 1'b0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            vcnt  <= vcnt_n;
            // Follows the state register by one cycle, same lag as href/px_data.
            vsync <= (state == ST_VSYNC);
        end
    end

    always_comb begin
        state_n     = state;
        hcnt_n      = hcnt;
        vcnt_n      = vcnt;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        last_line   = 1'b0;

        case (state)
            ST_VSYNC:  last_line = (vcnt == VS_LAST);
            ST_VBP:    last_line = (vcnt == VBP_LAST);
            ST_ACTIVE: last_line = (vcnt == ACT_LAST);
            ST_VFP:    last_line = (vcnt == VFP_LAST);
            default:   last_line = 1'b0;
        endcase

        if (state == ST_IDLE) begin
            // Counters are already zero here; en is only looked at between frames.
            if (en) begin
                state_n     = ST_VSYNC;
                frame_start = 1'b1;
            end
        end else begin
            hcnt_n = line_end ? '0 : hcnt + 1'b1;
            if (line_end) begin
                vcnt_n = last_line ? '0 : vcnt + 1'b1;
                if (last_line) begin
                    case (state)
                        ST_VSYNC:  state_n = ST_VBP;
                        ST_VBP:    state_n = ST_ACTIVE;
                        ST_ACTIVE: state_n = ST_VFP;
                        ST_VFP: begin
                            frame_end = 1'b1;
                            if (en) begin
                                state_n     = ST_VSYNC;
                                frame_start = 1'b1;
                            end else begin
                                state_n = ST_IDLE;
                            end
                        end
                        default:   state_n = ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/cam_frame_gen.sv
// OV7670-style parallel transmitter replaying an RGB332 frame buffer as RGB565 bytes.
// Ports: pclk, rst (sync, active-low), en in; mem_px_addr/mem_rd out, mem_px_data in (1-cycle latency);
//        vsync, href, px_data, frame_done out, all registered.
module cam_frame_gen
    import cam_pkg::*;
#(
    parameter int AW          = 15,
    parameter int H_ACT       = 160,
    parameter int V_ACT       = 120,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] mem_px_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_px_data,
    output logic          vsync,
    output logic          href,
    output logic [7:0]    px_data,
    output logic          frame_done
);

    localparam int LL = line_len(H_ACT, H_BLANK);
    localparam int HW = $clog2(LL);

    if (H_ACT * V_ACT > (64'd1 << AW)) begin : g_aw_too_small
        $error("cam_frame_gen: H_ACT*V_ACT does not fit in AW address bits");
    end
    if (H_BLANK < 4) begin : g_hblank_too_small
        $error("cam_frame_gen: H_BLANK must be at least 4");
    end

    // Read for pixel p is launched at hcnt = H_BLANK + 2p - 3: mem_rd shows one
    // cycle later, data arrives the cycle after, and the pixel register is loaded
    // just in time for byte1 computed at hcnt = H_BLANK + 2p.
    localparam int            RD_FIRST   = H_BLANK - 3;
    localparam int            RD_LAST    = LL - 5;
    localparam logic [HW-1:0] RD_FIRST_C = HW'(RD_FIRST);
    localparam logic [HW-1:0] RD_LAST_C  = HW'(RD_LAST);
    localparam logic          RD_PAR     = 1'(RD_FIRST % 2);
    localparam logic          BYTE_PAR   = 1'(H_BLANK % 2);

    logic [HW-1:0] hcnt;
    logic          href_early;
    logic          in_active;
    logic          frame_start;
    logic          frame_end;
    logic          rd_go;
    logic          rd_d;
    logic [AW-1:0] addr_cnt;
    logic [7:0]    pix;
    logic [7:0]    byte_sel;

    cam_sync_gen #(
        .H_ACT       (H_ACT),
        .V_ACT       (V_ACT),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .VBP_LINES   (VBP_LINES),
        .VFP_LINES   (VFP_LINES)
    ) u_sync (
        .clk         (pclk),
        .rst         (rst),
        .en          (en),
        .vsync       (vsync),
        .href_early  (href_early),
        .in_active   (in_active),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .hcnt        (hcnt)
    );

    assign rd_go = in_active && (hcnt >= RD_FIRST_C) && (hcnt <= RD_LAST_C)
                   && (hcnt[0] == RD_PAR);

    // Even byte index k within the active window carries the high byte.
    assign byte_sel = (hcnt[0] == BYTE_PAR) ? rgb332_to_565_hi(pix)
                                            : rgb332_to_565_lo(pix);

    always_ff @(posedge pclk) begin
        if (!rst) begin
            mem_rd      <= 1'b0;
            mem_px_addr <= '0;
            addr_cnt    <= '0;
            rd_d        <= 1'b0;
            pix         <= '0;
            href        <= 1'b0;
            px_data     <= '0;
            frame_done  <= 1'b0;
        end else begin
            mem_rd <= rd_go;
            rd_d   <= mem_rd;
            if (rd_go) begin
                mem_px_addr <= addr_cnt;
            end
            if (frame_start) begin
                addr_cnt <= '0;
            end else if (rd_go) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (rd_d) begin
                pix <= mem_px_data;
            end
            href       <= href_early;
            px_data    <= href_early ? byte_sel : 8'h00;
            frame_done <= frame_end;
        end
    end

endmodule

// File: doc/cam_frame_gen.md
Name: cam_frame_gen

Overview:
- Camera-side transmitter that emulates an OV7670-style parallel sensor.
- Reads an RGB332 frame buffer and replays it as vsync/href/px_data, with two RGB565 bytes per pixel.
- Sits opposite the capture path; used for loopback tests of capture logic and for board bring-up without a sensor.
- Output is bit-compatible with the team's capture block: after capture, every RGB332 pixel reads back unchanged.

Parameters:
- AW, 15: frame-buffer address width.
- H_ACT, 160: active pixels per line.
- V_ACT, 120: active lines per frame.
- H_BLANK, 144: pclk cycles of href-low per line; must be ≥ 4.
- VSYNC_LINES, 3: lines with vsync high.
- VBP_LINES, 17: blank lines after vsync, before active video.
- VFP_LINES, 10: blank lines after active video.

Ports:
- pclk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-low reset.
- en, in, 1: frame enable; sampled at frame start.
- mem_px_addr, out, AW: frame-buffer read address.
- mem_rd, out, 1: read strobe.
- mem_px_data, in, 8: RGB332 read data; valid exactly 1 cycle after mem_rd.
- vsync, out, 1: frame sync, active high.
- href, out, 1: line-valid.
- px_data, out, 8: RGB565 byte stream.
- frame_done, out, 1: one-cycle pulse at end of frame.

Behaviour:
- Line length L = 2*H_ACT + H_BLANK pclk. Every line type (sync, blank, active) lasts exactly L cycles.
- Reset (rst=0 at an edge): all outputs 0 on the next edge; FSM goes to IDLE; counters clear. Reset mid-frame aborts immediately, with no frame_done.
- FSM states: IDLE, VSYNC, VBP, ACTIVE, VFP.
  - IDLE: if en=1, go to VSYNC on the next cycle.
  - VSYNC: vsync=1 for VSYNC_LINES*L cycles, then VBP.
  - VBP: VBP_LINES*L cycles, then ACTIVE.
  - ACTIVE: V_ACT lines, then VFP.
  - VFP: VFP_LINES*L cycles. In the last cycle frame_done=1. Then go to VSYNC if en=1, else IDLE.
- en is checked only at frame boundaries. Deasserting it mid-frame completes the current frame.
- vsync, href and px_data are registered outputs, with no combinational path from inputs.
- Active line layout:
  - H_BLANK cycles with href=0, then 2*H_ACT cycles with href=1.
  - Byte k (k = 0..2*H_ACT-1) carries pixel p = k/2.
  - Even k: byte1 = {r[2:0], r[2:1], g[2:0]}.
  - Odd k: byte2 = {g[2:0], b[1:0], b[1:0], b[1]}.
  - Here {r,g,b} = RGB332 {[7:5],[4:2],[1:0]}.
- px_data = 0 whenever href = 0.
- Reads:
  - One mem_rd pulse per pixel, with mem_px_addr held in that cycle.
  - The read for pixel p is issued no later than 2 cycles before its byte1.
  - mem_px_data is latched into a pixel register 1 cycle after mem_rd.
  - mem_rd = 0 outside ACTIVE.
- Addressing:
  - Address = line*H_ACT + p, zeroed at VSYNC entry.
  - Last address = H_ACT*V_ACT - 1 (19199 at default values).
  - No wrap within a frame. The next frame restarts at 0.
- Width rules:
  - Horizontal counter width: clog2(L).
  - Line counter width: clog2(max vertical region).
  - The address counter width is AW. Elaboration must fail if H_ACT*V_ACT > 2^AW.
- Edges: vsync rises and falls on line boundaries. href never overlaps vsync=1.

Decomposition:
- Shared package cam_pkg holds:
  - FSM state encoding.
  - Localparam L.
  - Function rgb332_to_565_hi/lo, returning the two bytes.
- Natural sub-module: cam_sync_gen. It holds the horizontal/vertical counters and the FSM, and outputs vsync, href_early, line_start and pixel index.
- cam_frame_gen keeps the read pipeline and the byte mux.

Test Plan:
- Reset: hold rst=0 for 5 cycles with en=1 → vsync=href=mem_rd=frame_done=0 and px_data=0x00. Release → vsync rises 1 cycle after the first edge with rst=1.
- Small frame: H_ACT=4, V_ACT=2, H_BLANK=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1 (L=12), en held high → vsync high 12 cycles; 2 href pulses of 8 cycles each; frame_done once every 60 cycles.
- Encoding:
  - memory[0]=0xE3 → bytes 0xF8, 0x1F.
  - memory[1]=0x1C → bytes 0x07, 0xE0.
  - 0xFF → 0xFF, 0xFF.
  - 0x00 → 0x00, 0x00.
- Loopback at default parameters: connect outputs to the capture block; preload the frame buffer with address[7:0] as pixel values → capture memory matches all 19200 entries.
- en drop: clear en in the middle of ACTIVE line 50 → the frame completes (120 href pulses); frame_done pulses; FSM stays in IDLE with vsync=0.
- Reset mid-frame: assert rst during an href-high cycle of line 10 → href=0 and px_data=0 on the next edge; no frame_done. The next frame starts at address 0.
